// File: rtl/rle_pkg.sv
// Shared constants, FSM encoding and byte-packing helper for the row RLE codec.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: byte layout constants, rle_state_t, rle_pack().
package rle_pkg;

  // Encoded byte layout: {value[7], length[6:0]}.
  localparam int RLE_BYTE_W  = 8;
  localparam int RLE_LEN_MSB = 6;
  localparam int RLE_VAL_BIT = 7;
  localparam int RLE_MAX_RUN = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } rle_state_t;

  function automatic logic [RLE_BYTE_W-1:0] rle_pack(input logic val,
                                                     input logic [RLE_LEN_MSB:0] len);
    logic [RLE_BYTE_W-1:0] b;
    b = '0;
    b[RLE_VAL_BIT]     = val;
    b[RLE_LEN_MSB:0]   = len;
    return b;
  endfunction

endpackage

// File: rtl/rle_out_reg.sv
// Output holding register for the RLE byte stream (byte + last flag).
// Latency: a loaded byte is presented on out_valid the cycle after load.
// Backpressure: byte/last held stable until out_ready; valid only drops on a handshake.
// Ports: load/load_byte/load_last from the FSM, out_ready from consumer,
//        out_valid/out_byte/out_last to consumer, fire = handshake this cycle.
module rle_out_reg
  import rle_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [RLE_BYTE_W-1:0] load_byte,
  input  logic                  load_last,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [RLE_BYTE_W-1:0] out_byte,
  output logic                  out_last,
  output logic                  fire
);

  assign fire = out_valid & out_ready;

  // The FSM only loads when the register is empty or draining this cycle,
  // so a held byte can never be overwritten.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_byte  <= '0;
      out_last  <= 1'b0;
    end else if (load && (!out_valid || fire)) begin
      out_valid <= 1'b1;
      out_byte  <= load_byte;
      out_last  <= load_last;
    end else if (fire) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/rle_compress.sv
// Run-length encoder for one binary row, MSB first, one bit per clock, {val,len} bytes out.
// Latency: first byte valid <= MAX_RUN+1 cycles after accept; row <= ROW_W + bytes + 1 cycles.
// Backpressure: scanning stalls while a byte is held; row input blocked (in_ready=0) until done.
// Ports: in_valid/in_ready/in_row row input; out_valid/out_ready/out_byte/out_last byte stream;
//        byte_count bytes of current row; busy accept..final handshake; done pulse after it.
module rle_compress
  import rle_pkg::*;
#(
  parameter int ROW_W   = 256,
  parameter int MAX_RUN = RLE_MAX_RUN,
  parameter int CNT_W   = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ROW_W-1:0]      in_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RLE_BYTE_W-1:0] out_byte,
  output logic                  out_last,
  output logic [CNT_W-1:0]      byte_count,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = $clog2(ROW_W);
  localparam logic [RLE_LEN_MSB:0] MAX_LEN  = (RLE_LEN_MSB+1)'(MAX_RUN);
  localparam logic [RLE_LEN_MSB:0] LEN_ONE  = (RLE_LEN_MSB+1)'(1);
  localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]     IDX_INIT = IDX_W'(ROW_W-2);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  rle_state_t state_q, state_d;

  // Bit ROW_W-1 seeds the first run directly, so only the rest is stored.
  logic [ROW_W-2:0]       row_q;
  logic                   run_val_q;
  logic [RLE_LEN_MSB:0]   run_len_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   pending_val_q;
  logic                   trail_q;

  logic                   cur_bit;
  logic                   absorb;
  logic                   at_end;

  logic                   load;
  logic [RLE_BYTE_W-1:0]  load_byte;
  logic                   load_last;
  logic                   fire;

  rle_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_byte (load_byte),
    .load_last (load_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .fire      (fire)
  );

  always_comb begin
    cur_bit = row_q[idx_q];
    absorb  = (cur_bit == run_val_q) && (run_len_q < MAX_LEN);
    at_end  = (idx_q == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = SCAN;
      SCAN: if (!absorb || at_end) state_d = EMIT;
      EMIT: begin
        if (fire) begin
          if (out_last)      state_d = IDLE;
          else if (!trail_q) state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / load control
  always_comb begin
    in_ready  = 1'b0;
    load      = 1'b0;
    load_byte = '0;
    load_last = 1'b0;
    case (state_q)
      IDLE: in_ready = 1'b1;
      SCAN: begin
        // Last bit absorbed closes the row with the extended run; otherwise
        // the current run is flushed and the mismatching bit becomes pending.
        if (absorb && at_end) begin
          load      = 1'b1;
          load_byte = rle_pack(run_val_q, run_len_q + LEN_ONE);
          load_last = 1'b1;
        end else if (!absorb) begin
          load      = 1'b1;
          load_byte = rle_pack(run_val_q, run_len_q);
          load_last = 1'b0;
        end
      end
      EMIT: begin
        // Trailing single-bit run when the final bit started a new run.
        if (fire && !out_last && trail_q) begin
          load      = 1'b1;
          load_byte = rle_pack(pending_val_q, LEN_ONE);
          load_last = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Scan datapath and status
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q         <= '0;
      run_val_q     <= 1'b0;
      run_len_q     <= '0;
      idx_q         <= '0;
      pending_val_q <= 1'b0;
      trail_q       <= 1'b0;
      byte_count    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            row_q      <= in_row[ROW_W-2:0];
            run_val_q  <= in_row[ROW_W-1];
            run_len_q  <= LEN_ONE;
            idx_q      <= IDX_INIT;
            byte_count <= '0;
            busy       <= 1'b1;
          end
        end
        SCAN: begin
          if (absorb && !at_end) begin
            run_len_q <= run_len_q + LEN_ONE;
            idx_q     <= idx_q - IDX_ONE;
          end else if (!absorb) begin
            pending_val_q <= cur_bit;
            trail_q       <= at_end;
          end
        end
        EMIT: begin
          if (fire) begin
            byte_count <= byte_count + CNT_ONE;
            if (out_last) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else if (trail_q) begin
              trail_q <= 1'b0;
            end else begin
              // The mismatching bit opens the new run; idx > 0 here because
              // an end-of-row mismatch always takes the trailing path.
              run_val_q <= pending_val_q;
              run_len_q <= LEN_ONE;
              idx_q     <= idx_q - IDX_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_compress.sv
module tb_rle_compress;
  import rle_pkg::*;

  localparam int ROW_W = 256;
  localparam int CNT_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [ROW_W-1:0] in_row;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             out_last;
  logic [CNT_W-1:0] byte_count;
  logic             busy;
  logic             done;

  rle_compress #(.ROW_W(ROW_W), .MAX_RUN(127), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_last   (out_last),
    .byte_count (byte_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  logic [8:0] exp_q[$];   // {last, byte}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference encoder: plain run-length split at 127, final byte marked last.
  task automatic push_expected(input logic [ROW_W-1:0] r, output int nbytes);
    logic [8:0] tmp[$];
    logic v;
    int len;
    v = r[ROW_W-1];
    len = 0;
    for (int i = ROW_W-1; i >= 0; i--) begin
      if (r[i] == v && len < 127) len++;
      else begin
        tmp.push_back({1'b0, v, 7'(len)});
        v = r[i];
        len = 1;
      end
    end
    tmp.push_back({1'b1, v, 7'(len)});
    nbytes = tmp.size();
    foreach (tmp[k]) exp_q.push_back(tmp[k]);
  endtask

  // Output monitor: scoreboard pop on handshake plus hold-stability checks.
  logic       prev_hold = 1'b0;
  logic [7:0] prev_byte;
  logic       prev_last;
  logic [8:0] e;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_byte",  32'(out_byte),  32'(prev_byte));
        chk("hold_last",  32'(out_last),  32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("extra_byte", 32'(out_byte), 32'hFFFF);
        else begin
          e = exp_q.pop_front();
          chk("byte", 32'(out_byte), 32'(e[7:0]));
          chk("last", 32'(out_last), 32'(e[8]));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_byte = out_byte;
      prev_last = out_last;
      if (done) done_cnt++;
    end
  end

  // mode 0: out_ready always high; mode 1: 5-cycle out_ready gap and in_valid while busy.
  task automatic run_row(input string name, input logic [ROW_W-1:0] r, input int mode);
    int nb;
    int cyc;
    push_expected(r, nb);
    done_cnt = 0;
    @(posedge clk); #1;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_row   = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (mode == 1) begin
        out_ready = !(cyc >= 10 && cyc < 15);
        if (cyc >= 2 && cyc < 30) begin
          in_valid = 1'b1;
          in_row   = ~r;
          chk({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        end else in_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (done_cnt == 0) chk({name, "_timeout"}, 32'd0, 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({name, "_left_in_q"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_byte_count"}, 32'(byte_count), 32'(nb));
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    chk({name, "_in_ready_end"}, 32'(in_ready), 32'd1);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_row = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_byte",   32'(out_byte),   32'd0);
    chk("rst_out_last",   32'(out_last),   32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_done",       32'(done),       32'd0);
    rst = 1'b0;

    run_row("zeros",  '0, 0);
    run_row("top100", {{100{1'b1}}, {156{1'b0}}}, 0);
    run_row("alt",    {128{2'b10}}, 0);
    run_row("bit0",   256'd1, 0);
    run_row("f0_bp",  {32{8'hF0}}, 1);
    run_row("rand",   {8{$urandom()}}, 0);

    // Reset in the middle of scanning an all-zero row (no byte before ~127 cycles).
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_row   = '0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid",  32'(out_valid),  32'd0);
    chk("mid_rst_busy",       32'(busy),       32'd0);
    chk("mid_rst_in_ready",   32'(in_ready),   32'd1);
    chk("mid_rst_byte_count", 32'(byte_count), 32'd0);
    repeat (150) @(posedge clk);
    #1;
    chk("mid_rst_silent", 32'(out_valid), 32'd0);

    run_row("ones", '1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rle_compress.md
Name: rle_compress

Overview:
- Run-length encoder for one binary feature-map row.
- Accepts a ROW_W-bit row and emits a byte stream, each byte = {bit value [7], run length [6:0]}.
- It is the transmit-side counterpart of the row decompressor and sits between the feature-map buffer and the IO output path.
- Scans one bit per clock, MSB (bit ROW_W-1) first, with valid/ready handshakes on both sides.

Parameters:
- ROW_W, 256, row width in bits; must be ≥ 2.
- MAX_RUN, 127, longest run per byte; must be ≤ 127. Longer runs are split across bytes.
- CNT_W, 9, width of byte_count; must hold ROW_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  row offered.
- in_ready  out  1  block can accept a row.
- in_row  in  ROW_W  row data; bit ROW_W-1 is encoded first.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  consumer accepts out_byte.
- out_byte  out  8  {value, length}; length is always 1..MAX_RUN, never 0.
- out_last  out  1  marks the final byte of the row; qualified by out_valid.
- byte_count  out  CNT_W  bytes emitted for the current/last row; updates on each out handshake.
- busy  out  1  high from row accept until the final byte handshake.
- done  out  1  one-cycle pulse the cycle after the final byte handshake.

Behaviour:
- Reset (sync, active-high) values: in_ready=1, out_valid=0, out_byte=0, out_last=0, byte_count=0, busy=0, done=0. All state returns to IDLE.
- Reset mid-row abandons the row; no further bytes are emitted. Reset has priority over all other events.
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_row, run_val=in_row[ROW_W-1], run_len=1, idx=ROW_W-2, byte_count=0, busy=1, then go to SCAN.
  - in_ready=0 in every other state; in_valid is ignored there.
- SCAN, examining bit b=row[idx] each cycle:
  - If b==run_val and run_len<MAX_RUN: run_len+1.
  - Otherwise: register out_byte={run_val,run_len[6:0]}, set out_valid=1, set pending_val=b, go to EMIT.
  - On the idx==0 cycle: if b was absorbed, emit immediately with out_last=1. If b started a new run, emit the current byte and flag a trailing 1-length byte.
  - idx decrements each cycle with no wrap; it is never read below 0.
- EMIT:
  - out_byte, out_valid and out_last hold stable until out_ready. Back-pressure may last any length.
  - On handshake, byte_count+1.
  - If out_last: busy=0, done=1 next cycle, return to IDLE.
  - Else if a trailing byte is flagged: present {pending_val,1} with out_last=1 next cycle.
  - Else: reload run_val=pending_val, run_len=1, continue SCAN at idx-1.
- out_valid must not drop without a handshake. out_byte must not change while out_valid=1 and out_ready=0.
- Row-end timing:
  - A run ends exactly when the row ends.
  - When the last bit mismatches, the final byte is {b,1}.
  - When a run reaches MAX_RUN at idx 0, the final byte is the full run; no zero-length byte is emitted.
- Latency:
  - First byte valid no later than MAX_RUN+1 cycles after accept.
  - With out_ready held high, a row takes ≤ ROW_W + (bytes emitted) + 1 cycles.
- Invariants: the sum of lengths equals ROW_W; byte_count ≥ ceil(ROW_W/MAX_RUN).

Decomposition:
- Shared package rle_pkg:
  - RLE_BYTE_W=8, RLE_LEN_MSB=6, RLE_VAL_BIT=7, RLE_MAX_RUN=127.
  - FSM state enum.
  - The same constants are to be adopted by the decompressor.
- One natural sub-module, rle_out_reg: the output holding register with valid/ready/last, which enforces the stability rules.
- The scan datapath and FSM stay in rle_compress.

Test Plan:
- All-zero row, out_ready=1 → bytes 0x7F, 0x7F, 0x02 (last); byte_count=3; done pulse once.
- Row with top 100 bits=1, rest 0 → 0xE4, 0x7F, 0x1D (last); lengths sum to 256.
- Alternating row starting 1 (0xAAAA…) → 256 bytes alternating 0x81/0x01; final 0x01 has out_last=1; byte_count=256.
- Row with only bit 0 = 1 → 0x7F, 0x7F, 0x01, 0x81 (last); checks the final-bit-mismatch trailing byte.
- out_ready low for 5 cycles mid-row → out_byte/out_last stable, no byte lost or duplicated; in_valid asserted while busy is ignored (in_ready=0).
- rst asserted in SCAN after 40 cycles → next cycle out_valid=0, busy=0, in_ready=1, byte_count=0; a fresh all-ones row then yields 0xFF, 0xFF, 0x82.
